// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch: controller states, seconds modulus, BCD digit.
package stopwatch_pkg;
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } sw_state_t;

  localparam int SEC_MAX = 59;

  typedef logic [3:0] bcd_t;
endpackage

// File: rtl/stopwatch_if.sv
// Control/display bundle of the stopwatch. master = driver of ticks and
// buttons, slave = the counter block producing digits and status.
interface stopwatch_if;
  import stopwatch_pkg::*;

  logic tick_1hz;
  logic tick_2hz;
  logic pause_pulse;
  logic adj;
  logic sel;
  bcd_t min_tens;
  bcd_t min_ones;
  bcd_t sec_tens;
  bcd_t sec_ones;
  logic blink_min;
  logic blink_sec;
  logic paused;
  logic rollover;

  modport master (
    output tick_1hz, tick_2hz, pause_pulse, adj, sel,
    input  min_tens, min_ones, sec_tens, sec_ones,
    input  blink_min, blink_sec, paused, rollover
  );

  modport slave (
    input  tick_1hz, tick_2hz, pause_pulse, adj, sel,
    output min_tens, min_ones, sec_tens, sec_ones,
    output blink_min, blink_sec, paused, rollover
  );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter counting 0..MAX and wrapping to 0.
// carry is combinational: high when an increment is wrapping the counter.
module bcd_mod_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output bcd_t tens,
  output bcd_t ones,
  output logic at_max,
  output logic carry
);
  localparam bcd_t MAX_T = bcd_t'(MAX / 10);
  localparam bcd_t MAX_O = bcd_t'(MAX % 10);

  assign at_max = (tens == MAX_T) && (ones == MAX_O);
  assign carry  = inc && at_max;

  // Digit registers: wrap at MAX, otherwise decimal increment of the ones digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens <= '0;
      ones <= '0;
    end else if (clr) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      if (at_max) begin
        tens <= '0;
        ones <= '0;
      end else if (ones == 4'd9) begin
        tens <= tens + 4'd1;
        ones <= '0;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end
endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch with RUN / PAUSED / ADJUST control.
// Build option: STOPWATCH_SATURATE_EN -- when defined, the RUN count holds at
// MAX_MIN:59 instead of wrapping to 00:00, and rollover marks the arrival there.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = 99
) (
  input  logic clk,
  input  logic rst_n,
  stopwatch_if.slave sw
);
  sw_state_t state_q, state_d;
  logic      pause_flag_q, pause_flag_d;
  logic      rollover_q, rollover_d;

  bcd_t sec_tens, sec_ones, min_tens, min_ones;
  logic sec_at_max, sec_carry, min_at_max, min_carry;
  logic run_tick, adj_tick, terminal;
  logic sec_inc, min_inc;

  // Controller: adj always wins; otherwise pause requests flip RUN/PAUSED and
  // leaving ADJUST returns to whichever side the pause flag remembers.
  always_comb begin
    state_d      = state_q;
    pause_flag_d = pause_flag_q ^ sw.pause_pulse;
    if (sw.adj) begin
      state_d = ST_ADJUST;
    end else begin
      case (state_q)
        ST_RUN:    if (sw.pause_pulse) state_d = ST_PAUSED;
        ST_PAUSED: if (sw.pause_pulse) state_d = ST_RUN;
        ST_ADJUST: state_d = pause_flag_d ? ST_PAUSED : ST_RUN;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  // Controller state and remembered pause choice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      pause_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pause_flag_q <= pause_flag_d;
    end
  end

  assign run_tick = (state_q == ST_RUN) && sw.tick_1hz;
  assign adj_tick = (state_q == ST_ADJUST) && sw.tick_2hz;
  assign terminal = sec_at_max && min_at_max;

  // Increment enables. In ADJUST only the selected field moves and the seconds
  // carry is masked so fields stay independent.
`ifdef STOPWATCH_SATURATE_EN
  always_comb begin
    sec_inc    = (run_tick && !terminal) || (adj_tick && sw.sel);
    min_inc    = (run_tick && !terminal && sec_carry) || (adj_tick && !sw.sel);
    rollover_d = run_tick && min_at_max && (sec_tens == 4'd5) && (sec_ones == 4'd8);
  end
`else
  always_comb begin
    sec_inc    = run_tick || (adj_tick && sw.sel);
    min_inc    = (run_tick && sec_carry) || (adj_tick && !sw.sel);
    rollover_d = run_tick && min_carry;
  end
`endif

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (sec_inc),
    .clr    (1'b0),
    .tens   (sec_tens),
    .ones   (sec_ones),
    .at_max (sec_at_max),
    .carry  (sec_carry)
  );

  bcd_mod_counter #(.MAX(MAX_MIN)) u_min (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (min_inc),
    .clr    (1'b0),
    .tens   (min_tens),
    .ones   (min_ones),
    .at_max (min_at_max),
    .carry  (min_carry)
  );

  // Rollover pulse lines up with the cycle the new digits are shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rollover_q <= 1'b0;
    else        rollover_q <= rollover_d;
  end

  assign sw.sec_tens  = sec_tens;
  assign sw.sec_ones  = sec_ones;
  assign sw.min_tens  = min_tens;
  assign sw.min_ones  = min_ones;
  assign sw.rollover  = rollover_q;
  assign sw.paused    = (state_q == ST_PAUSED);
  assign sw.blink_min = (state_q == ST_ADJUST) && !sw.sel;
  assign sw.blink_sec = (state_q == ST_ADJUST) && sw.sel;
endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 Parameter MAX_MIN, default 99: highest minutes value, legal range 1..99.
REQ-002 Port clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port tick_1hz  input  1  one-cycle enable pulse, 1 Hz, from the clock-divider stage.
REQ-005 Port tick_2hz  input  1  one-cycle enable pulse, 2 Hz, from the clock-divider stage.
REQ-006 Port pause_pulse  input  1  debounced one-cycle pause-toggle request.
REQ-007 Port adj  input  1  level; 1 = adjust mode.
REQ-008 Port sel  input  1  level; 0 = adjust minutes, 1 = adjust seconds.
REQ-009 Port min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD digits, registered.
REQ-010 Port blink_min, blink_sec  output  1 each  high while the field is being adjusted.
REQ-011 Port paused  output  1  high in PAUSED.
REQ-012 Port rollover  output  1  one-cycle pulse on the terminal-count event.

Function
REQ-013 States RUN, PAUSED, ADJUST; internal pause_flag records the RUN/PAUSED choice.
REQ-014 adj=1 -> ADJUST next cycle from any state; adj=0 in ADJUST -> PAUSED if pause_flag else RUN.
REQ-015 pause_pulse toggles pause_flag in every state; in RUN/PAUSED it moves the state immediately (next edge).
REQ-016 RUN, tick_1hz high: seconds +1; 59 -> 00 with minutes +1; digits valid the cycle after the sampling edge.
REQ-017 Terminal count MAX_MIN:59 + tick -> 00:00, rollover=1 for exactly that cycle.
REQ-018 PAUSED: digits hold; tick_1hz and tick_2hz ignored.
REQ-019 ADJUST: tick_1hz ignored; on tick_2hz the sel field +1 only — minutes wrap MAX_MIN -> 0, seconds wrap 59 -> 0, no carry between fields, rollover stays 0.
REQ-020 blink_min = ADJUST & ~sel; blink_sec = ADJUST & sel; both 0 outside ADJUST.
REQ-021 Same-cycle tick_1hz and pause_pulse in RUN: the tick is counted and the state becomes PAUSED.
REQ-022 sel change in the same cycle as tick_2hz: the new sel value selects the field.
REQ-023 tick_1hz and tick_2hz both high in ADJUST: one increment only (from tick_2hz).
REQ-024 Digit values above 9, and tens-of-seconds above 5, are unreachable.

Reset
REQ-025 rst_n low: all digits 0, state RUN, pause_flag 0, paused/rollover/blink outputs 0, applied immediately and asynchronously.
REQ-026 rst_n deasserted mid-count: counting resumes from 00:00 on the first tick_1hz after release.

Configuration
REQ-027 Macro STOPWATCH_SATURATE_EN defined: at MAX_MIN:59 in RUN further ticks hold the value; rollover pulses once on arrival at MAX_MIN:59, not on later ticks; adjust-mode wrap is unchanged.
REQ-028 Macro STOPWATCH_SATURATE_EN undefined: wrap behaviour per REQ-017.

Structure
REQ-029 Package stopwatch_pkg holds the state enum, SEC_MAX=59 and the BCD digit typedef.
REQ-030 Sub-module bcd_mod_counter (two-digit BCD, modulus parameter, inc/clear inputs, carry output) instantiated once for seconds and once for minutes.

Verification
REQ-031 Reset, then 61 tick_1hz in RUN -> digits 01:01, rollover never high.
REQ-032 Preload 99:59 via adjust, return to RUN, one tick_1hz -> 00:00, rollover high for 1 cycle; with STOPWATCH_SATURATE_EN -> stays 99:59.
REQ-033 pause_pulse then 5 tick_1hz -> digits unchanged, paused=1; second pause_pulse then 1 tick -> +1 second.
REQ-034 adj=1, sel=1, seconds at 58, 3 tick_2hz -> seconds 01, minutes unchanged, blink_sec=1, blink_min=0.
REQ-035 tick_1hz and pause_pulse in the same cycle at 00:10 -> 00:11 and paused=1.
REQ-036 rst_n asserted asynchronously between clock edges at 12:34 -> outputs 00:00 before the next edge.
